// File: rtl/compute_engine_16_acc_requant.sv
// Accumulate-and-requantize stage: sums cfg_len signed products plus a bias, then rounds, shifts and saturates to OUT_WIDTH.
// Optional macro COMPUTE_ENGINE_16_RELU_EN clamps negative results to zero after saturation.
module compute_engine_16_acc_requant #(
  parameter int PROD_WIDTH  = 24,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int LEN_WIDTH   = 10,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic        [LEN_WIDTH-1:0]   cfg_len,
  input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic signed [ACC_WIDTH-1:0]   cfg_bias,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [PROD_WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_sat,
  output logic                          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = -OUT_MAX - (ACC_WIDTH+1)'(1);

  logic [1:0]                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [LEN_WIDTH-1:0]         cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
  logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;
  logic                         out_valid_q, out_valid_d;
  logic                         accept, fire;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic [OUT_WIDTH:0]           sat_res;

  // Round half up, then arithmetic shift; one guard bit keeps the rounding add from overflowing.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic        [SHIFT_WIDTH-1:0] sh
  );
    logic signed [ACC_WIDTH:0] w;
    logic signed [ACC_WIDTH:0] rnd;
    w   = {a[ACC_WIDTH-1], a};
    rnd = '0;
    if (sh != '0) rnd = (ACC_WIDTH+1)'(1) << (sh - 1'b1);
    return (w + rnd) >>> sh;
  endfunction

  // Returns {sat, data}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH:0] r);
    logic [OUT_WIDTH:0] res;
    if (r > OUT_MAX)      res = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (r < OUT_MIN) res = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                  res = {1'b0, r[OUT_WIDTH-1:0]};
`ifdef COMPUTE_ENGINE_16_RELU_EN
    if (res[OUT_WIDTH-1]) res = '0;
`endif
    return res;
  endfunction

  assign in_ready = (state_q == S_IDLE) || (state_q == S_ACC);
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid_q & out_ready;
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
  assign sat_res  = saturate(round_shift(acc_q, shift_q));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
          if (int'(cfg_shift) > ACC_WIDTH - 1) shift_d = SHIFT_WIDTH'(ACC_WIDTH - 1);
          else                                 shift_d = cfg_shift;
          acc_d   = cfg_bias + prod_ext;
          cnt_d   = LEN_WIDTH'(1);
          state_d = (len_d == LEN_WIDTH'(1)) ? S_REQ : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = S_REQ;
        end
      end
      S_REQ: begin
        out_sat_d   = sat_res[OUT_WIDTH];
        out_data_d  = sat_res[OUT_WIDTH-1:0];
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      default: begin
        if (fire) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_compute_engine_16_acc_requant.sv
// Directed bench for compute_engine_16_acc_requant; expectations follow COMPUTE_ENGINE_16_RELU_EN when defined.
module tb_compute_engine_16_acc_requant;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [9:0]         cfg_len = '0;
  logic [4:0]         cfg_shift = '0;
  logic signed [31:0] cfg_bias = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [23:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  compute_engine_16_acc_requant dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .cfg_bias  (cfg_bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [9:0] len, input logic [4:0] sh, input logic signed [31:0] bias);
    cfg_len   = len;
    cfg_shift = sh;
    cfg_bias  = bias;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic signed [23:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [15:0] exp_d, input logic exp_s);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_d});
    check_eq({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_s});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_idle"}, {29'd0, busy, in_ready, out_valid}, 32'b010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_state", {12'd0, out_data, busy, in_ready, out_valid, out_sat}, 32'b0100);
    reset = 1'b1;
    @(negedge clk);

    // 1: basic accumulation and latency
    set_cfg(10'd4, 5'd0, 32'sd0);
    send(24'sd100);
    send(24'sd200);
    send(-24'sd50);
    send(24'sd7);
    check_eq("t1_lat_req", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("t1_lat_out", {31'd0, out_valid}, 32'd1);
    recv("t1", 16'd257, 1'b0);

    // 2: rounding with bias, and negative rounding
    set_cfg(10'd1, 5'd2, 32'sd10);
    send(24'sd5);
    recv("t2a", 16'd4, 1'b0);
    set_cfg(10'd1, 5'd1, 32'sd0);
    send(-24'sd3);
`ifdef COMPUTE_ENGINE_16_RELU_EN
    recv("t2b", 16'h0000, 1'b0);
`else
    recv("t2b", 16'hFFFF, 1'b0);
`endif
    set_cfg(10'd1, 5'd4, 32'sd0);
    send(24'sd24);
    recv("t2c", 16'd2, 1'b0);

    // 3: saturation both directions
    set_cfg(10'd2, 5'd0, 32'sd0);
    send(24'sh7FFFFF);
    send(24'sh7FFFFF);
    recv("t3_pos", 16'h7FFF, 1'b1);
    send(24'sh800000);
    send(24'sh800000);
`ifdef COMPUTE_ENGINE_16_RELU_EN
    recv("t3_neg", 16'h0000, 1'b0);
`else
    recv("t3_neg", 16'h8000, 1'b1);
`endif

    // 4: back-pressure in OUT, stray in_valid ignored
    set_cfg(10'd1, 5'd0, 32'sd0);
    send(24'sd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_hold_data", {16'd0, out_data}, 32'd1);
      check_eq("t4_hold_rdy", {30'd0, in_ready, out_valid}, 32'b01);
      in_valid = i[0];
      in_data  = 24'sd50;
      @(negedge clk);
    end
    in_valid = 1'b0;
    recv("t4", 16'd1, 1'b0);
    send(24'sd3);
    recv("t4_next", 16'd3, 1'b0);

    // 5: reset mid-group discards partial sum
    set_cfg(10'd4, 5'd0, 32'sd0);
    send(24'sd5);
    send(24'sd6);
    #2 reset = 1'b0;
    #1 check_eq("t5_rst", {29'd0, busy, in_ready, out_valid}, 32'b010);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_cfg(10'd2, 5'd0, 32'sd0);
    send(24'sd1);
    send(24'sd1);
    recv("t5", 16'd2, 1'b0);

    // 6: negative pass-through vs ReLU
    set_cfg(10'd1, 5'd0, 32'sd0);
    send(-24'sd300);
`ifdef COMPUTE_ENGINE_16_RELU_EN
    recv("t6", 16'h0000, 1'b0);
`else
    recv("t6", 16'hFED4, 1'b0);
`endif

    // Config is latched at first accept; len 0 behaves as 1
    set_cfg(10'd2, 5'd0, 32'sd1000);
    send(24'sd10);
    set_cfg(10'd1, 5'd3, 32'sd0);
    send(24'sd20);
    recv("t7_cfg_latch", 16'd1030, 1'b0);
    set_cfg(10'd0, 5'd0, 32'sd0);
    send(24'sd9);
    recv("t7_len0", 16'd9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
